irrigation_controller: RTL

Upstream control stage of the irrigation system. Conditions the raw board inputs: it synchronises and debounces the push button, the mode selector and the 3-bit water-level sensors. It runs the irrigation state machine and drives the fill and irrigation valves. It produces the 3-bit state code and 3-bit water code that the matrix display path renders.

---
 rtl/irrigation_pkg.sv | 22 ++
 rtl/irrigation_controller_debouncer.sv | 45 ++++
 rtl/irrigation_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/irrigation_pkg.sv
// Shared state codes, water-level patterns and level validation for the irrigation controller.
package irrigation_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FILLING    = 3'd1,
    IRRIGATING = 3'd2,
    WAIT       = 3'd3,
    MANUAL     = 3'd4,
    ERROR      = 3'd5
  } state_t;

  localparam logic [2:0] EMPTY = 3'b000;
  localparam logic [2:0] LOW   = 3'b001;
  localparam logic [2:0] MID   = 3'b011;
  localparam logic [2:0] FULL  = 3'b111;

  function automatic logic is_valid_level(input logic [2:0] lvl);
    return (lvl == EMPTY) || (lvl == LOW) || (lvl == MID) || (lvl == FULL);
  endfunction

endpackage

// File: rtl/irrigation_controller_debouncer.sv
// Two-flop synchroniser followed by a whole-word stability filter.
module input_debouncer #(
  parameter int               WIDTH     = 1,
  parameter int               CYCLES    = 50000,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    count;

  // cand is the previous synchronised word; a change of it restarts the run count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= RESET_VAL;
      sync   <= RESET_VAL;
      cand   <= RESET_VAL;
      stable <= RESET_VAL;
      count  <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      cand <= sync;
      if (sync == stable) begin
        count <= '0;
      end else if (sync != cand) begin
        count <= CW'(1);
      end else if (count == CW'(CYCLES - 1)) begin
        stable <= sync;
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/irrigation_controller.sv
// Irrigation state machine: conditions board inputs, sequences fill/irrigate/wait and drives valves.
module irrigation_controller
  import irrigation_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int IRRIGATE_TICKS  = 10,
  parameter int WAIT_TICKS      = 20,
  parameter int FILL_TIMEOUT    = 30
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       push_n,
  input  logic       selector,
  input  logic [2:0] water_raw,
  output logic [2:0] state_code,
  output logic [2:0] water_code,
  output logic       fill_valve,
  output logic       irrigate_valve,
  output logic       alarm
);

  localparam int TW = 16;

  logic       push_db;
  logic       push_prev;
  logic       push_pulse;
  logic       sel_db;
  logic [2:0] water_db;
  logic [2:0] state;
  logic [2:0] next_state;
  logic [TW-1:0] timer;
  logic       fill_next;
  logic       irr_next;
  logic       alarm_next;

  input_debouncer #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_push (
    .clock(clock), .reset_n(reset_n), .raw(push_n), .stable(push_db)
  );

  input_debouncer #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_sel (
    .clock(clock), .reset_n(reset_n), .raw(selector), .stable(sel_db)
  );

  input_debouncer #(.WIDTH(3), .CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(3'b000)) u_water (
    .clock(clock), .reset_n(reset_n), .raw(water_raw), .stable(water_db)
  );

  assign push_pulse = push_prev & ~push_db;
  assign state_code = state;
  assign water_code = water_db;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      push_prev <= 1'b1;
      timer     <= '0;
    end else begin
      state     <= next_state;
      push_prev <= push_db;
      if (next_state != state) begin
        timer <= '0;
      end else if (tick) begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    if (state > ERROR) begin
      next_state = IDLE;
    end else if (!is_valid_level(water_db)) begin
      next_state = ERROR;
    end else if (sel_db && state != ERROR) begin
      next_state = MANUAL;
    end else begin
      case (state)
        IDLE:
          next_state = (water_db == EMPTY || water_db == LOW) ? FILLING : IRRIGATING;
        FILLING:
          if (water_db == FULL) next_state = IRRIGATING;
          else if (tick && timer == TW'(FILL_TIMEOUT - 1)) next_state = ERROR;
        IRRIGATING:
          // EMPTY is tested first so it wins over a coincident final tick
          if (water_db == EMPTY) next_state = FILLING;
          else if (tick && timer == TW'(IRRIGATE_TICKS - 1)) next_state = WAIT;
        WAIT:
          if (tick && timer == TW'(WAIT_TICKS - 1)) next_state = IDLE;
        MANUAL:
          next_state = IDLE;
        ERROR:
          if (push_pulse) next_state = IDLE;
        default:
          next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    fill_next  = 1'b0;
    irr_next   = 1'b0;
    alarm_next = 1'b0;
    case (next_state)
      FILLING:    fill_next = 1'b1;
      IRRIGATING: irr_next  = 1'b1;
      MANUAL:
        if (state == MANUAL) begin
          if (water_db == EMPTY) irr_next = 1'b0;
          else if (push_pulse)   irr_next = ~irrigate_valve;
          else                   irr_next = irrigate_valve;
        end
      ERROR:      alarm_next = 1'b1;
      default: ;
    endcase
  end

  // valves and alarm are registered alongside the state so they share its timing
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fill_valve     <= 1'b0;
      irrigate_valve <= 1'b0;
      alarm          <= 1'b0;
    end else begin
      fill_valve     <= fill_next;
      irrigate_valve <= irr_next;
      alarm          <= alarm_next;
    end
  end

endmodule
